cpu_sequencer: RTL and testbench

//  Multi-cycle control FSM that sequences the yIF/yID/yEX/yDM/yWB/yPC datapath, replacing bench-driven clk/INT phasing.

---
 rtl/cpu_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB/yPC datapath.
// Loads the entry point, steps instructions through fetch..retire, and stops on count, halt, illegal opcode or timeout.
module cpu_sequencer #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      entry_point,
    input  logic [CNT_W-1:0] run_len,
    input  logic             halt_req,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [31:0]      ep_out,
    output logic             pc_int,
    output logic             pc_write,
    output logic             fetch_en,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             busy,
    output logic             done,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_EP, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_RETIRE, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LW, C_S, C_B, C_J, C_ILL
    } cls_t;

    state_t             state, state_nx;
    cls_t               cls_q, cls_nx;
    logic [WAIT_W-1:0]  wait_cnt, wait_nx;
    logic [CNT_W-1:0]   run_len_q;
    logic [CNT_W-1:0]   ret_inc;
    logic               halt_q;
    logic               start_acc, timeout_hit, illegal_hit, retire_now, in_run;

    function automatic cls_t classify(input logic [6:0] op);
        cls_t c;
        case (op)
            OP_R:    c = C_R;
            OP_I:    c = C_I;
            OP_LW:   c = C_LW;
            OP_S:    c = C_S;
            OP_B:    c = C_B;
            OP_J:    c = C_J;
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    // Next-state, class latch and wait-counter logic
    always_comb begin
        state_nx    = state;
        cls_nx      = cls_q;
        wait_nx     = '0;
        start_acc   = 1'b0;
        timeout_hit = 1'b0;
        illegal_hit = 1'b0;
        retire_now  = 1'b0;
        in_run      = (state != S_IDLE) && (state != S_DONE);
        ret_inc     = (retired == '1) ? retired : retired + CNT_W'(1);

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nx  = S_LOAD_EP;
                end
            end
            S_LOAD_EP: state_nx = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    cls_nx   = classify(opcode);
                    state_nx = S_DECODE;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nx    = S_DONE;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (cls_q == C_ILL) begin
                    illegal_hit = 1'b1;
                    state_nx    = S_DONE;
                end else begin
                    state_nx = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_LW, C_S: state_nx = S_MEM;
                    C_B:       state_nx = S_RETIRE;
                    default:   state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_nx = (cls_q == C_LW) ? S_WB : S_RETIRE;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nx    = S_DONE;
                end else begin
                    wait_nx = wait_cnt + WAIT_W'(1);
                end
            end
            S_WB: state_nx = S_RETIRE;
            S_RETIRE: begin
                retire_now = 1'b1;
                // A halt raised in this very cycle still stops after this instruction
                if (halt_q || halt_req || ((run_len_q != '0) && (ret_inc == run_len_q)))
                    state_nx = S_DONE;
                else
                    state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, run context and registered Moore outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cls_q       <= C_R;
            wait_cnt    <= '0;
            run_len_q   <= '0;
            halt_q      <= 1'b0;
            ep_out      <= '0;
            retired     <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            pc_int      <= 1'b0;
            pc_write    <= 1'b0;
            fetch_en    <= 1'b0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state    <= state_nx;
            cls_q    <= cls_nx;
            wait_cnt <= wait_nx;

            if (start_acc) begin
                ep_out      <= entry_point;
                run_len_q   <= run_len;
                retired     <= '0;
                halt_q      <= 1'b0;
                err_illegal <= 1'b0;
                err_timeout <= 1'b0;
            end else begin
                if (in_run && halt_req) halt_q <= 1'b1;
                if (retire_now) retired <= ret_inc;
                if (timeout_hit) err_timeout <= 1'b1;
                if (illegal_hit) err_illegal <= 1'b1;
            end

            pc_int    <= (state_nx == S_LOAD_EP);
            pc_write  <= (state_nx == S_LOAD_EP) || (state_nx == S_RETIRE);
            fetch_en  <= (state_nx == S_FETCH);
            reg_write <= (state_nx == S_WB);
            mem_read  <= (state_nx == S_MEM) && (cls_nx == C_LW);
            mem_write <= (state_nx == S_MEM) && (cls_nx == C_S);
            busy      <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done      <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: program runs, memory stalls, timeout, illegal, halt and reset.
module tb_cpu_sequencer;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic        clk, rst, start, halt_req, imem_ready, dmem_ready;
    logic [31:0] entry_point, ep_out;
    logic [15:0] run_len, retired;
    logic [6:0]  opcode;
    logic        pc_int, pc_write, fetch_en, reg_write, mem_read, mem_write;
    logic        busy, done, err_illegal, err_timeout;

    int checks = 0;
    int errors = 0;

    // Program and stimulus knobs for run_prog
    logic [6:0] prog [8];
    int prog_len, imem_delay, dmem_delay, halt_at_instr, busy_start_at;

    // Statistics gathered by run_prog
    int n_pcint, n_pcwrite, n_regwrite, n_memread, n_memwrite, n_fetch;
    int first_fetch, done_cyc, onehot_err;
    bit saw_done;

    cpu_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .entry_point(entry_point), .run_len(run_len),
        .halt_req(halt_req), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .ep_out(ep_out), .pc_int(pc_int), .pc_write(pc_write), .fetch_en(fetch_en),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .busy(busy),
        .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a run and plays the program with the configured memory latencies until done
    task automatic run_prog(input logic [31:0] ep, input logic [15:0] len);
        int k = 0, icnt = 0, mcnt = 0, sum;
        n_pcint = 0; n_pcwrite = 0; n_regwrite = 0; n_memread = 0; n_memwrite = 0;
        n_fetch = 0; first_fetch = -1; done_cyc = -1; onehot_err = 0; saw_done = 0;
        @(negedge clk);
        entry_point = ep; run_len = len; start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start = 1'b0;
            halt_req = 1'b0;
            if (done) begin
                saw_done = 1; done_cyc = c;
                break;
            end
            n_pcint    += int'(pc_int);
            n_pcwrite  += int'(pc_write);
            n_regwrite += int'(reg_write);
            n_memread  += int'(mem_read);
            n_memwrite += int'(mem_write);
            n_fetch    += int'(fetch_en);
            if (fetch_en && first_fetch < 0) first_fetch = c;
            sum = int'(fetch_en) + int'(mem_read) + int'(mem_write) + int'(reg_write) + int'(pc_write);
            if (sum > 1 || (pc_int && !pc_write)) onehot_err++;
            if (fetch_en) begin
                opcode = (k < prog_len) ? prog[k] : OP_R;
                imem_ready = (icnt >= imem_delay);
                if (imem_ready) begin k++; icnt = 0; end
                else icnt++;
            end else begin
                imem_ready = 1'b0; icnt = 0;
            end
            if (mem_read || mem_write) begin
                dmem_ready = (mcnt >= dmem_delay);
                mcnt++;
                if (halt_at_instr == k && mcnt == 1) halt_req = 1'b1;
            end else begin
                dmem_ready = 1'b0; mcnt = 0;
            end
            if (c == busy_start_at) begin
                start = 1'b1; entry_point = 32'h999; run_len = 16'd1;
            end
        end
        if (!saw_done) begin
            errors++;
            $display("FAIL run_done_timeout: done=%b required 1 within 300 cycles", done);
        end
    endtask

    task automatic defaults();
        prog_len = 0; imem_delay = 0; dmem_delay = 0; halt_at_instr = -1; busy_start_at = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        opcode = '0; entry_point = 32'h1234; run_len = 16'd5;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({pc_int, pc_write, fetch_en, reg_write, mem_read, mem_write, busy, done, err_illegal, err_timeout} !== 10'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0", {pc_int, pc_write, fetch_en, reg_write, mem_read, mem_write, busy, done, err_illegal, err_timeout});
        end
        checks++;
        if (ep_out !== 32'h0) begin errors++; $display("FAIL reset_ep: got %h required 0", ep_out); end
        checks++;
        if (retired !== 16'h0) begin errors++; $display("FAIL reset_retired: got %0d required 0", retired); end
    endtask

    task automatic test_basic();
        defaults();
        prog[0] = OP_R; prog[1] = OP_I; prog[2] = OP_B; prog_len = 3;
        run_prog(32'h28, 16'd3);
        checks++;
        if (ep_out !== 32'h28) begin errors++; $display("FAIL basic_ep: got %h required 28", ep_out); end
        checks++;
        if (n_pcint !== 1) begin errors++; $display("FAIL basic_pcint: got %0d required 1", n_pcint); end
        checks++;
        if (retired !== 16'd3) begin errors++; $display("FAIL basic_retired: got %0d required 3", retired); end
        checks++;
        if ({done, busy, err_illegal, err_timeout} !== 4'b1000) begin
            errors++; $display("FAIL basic_status: got %b required 1000", {done, busy, err_illegal, err_timeout});
        end
        checks++;
        if (done_cyc - first_fetch !== 14) begin errors++; $display("FAIL basic_latency: got %0d required 14", done_cyc - first_fetch); end
        checks++;
        if (n_pcwrite !== 4 || n_regwrite !== 2) begin
            errors++; $display("FAIL basic_writes: pc_write %0d reg_write %0d required 4 2", n_pcwrite, n_regwrite);
        end
        checks++;
        if (onehot_err !== 0) begin errors++; $display("FAIL basic_onehot: got %0d violations required 0", onehot_err); end
    endtask

    task automatic test_mem_stall();
        defaults();
        prog[0] = OP_LW; prog[1] = OP_S; prog_len = 2; dmem_delay = 4;
        run_prog(32'h40, 16'd2);
        checks++;
        if (n_memread !== 5) begin errors++; $display("FAIL mem_read_cycles: got %0d required 5", n_memread); end
        checks++;
        if (n_memwrite !== 5) begin errors++; $display("FAIL mem_write_cycles: got %0d required 5", n_memwrite); end
        checks++;
        if (n_regwrite !== 1) begin errors++; $display("FAIL mem_reg_write: got %0d required 1", n_regwrite); end
        checks++;
        if (n_pcwrite !== 3 || retired !== 16'd2) begin
            errors++; $display("FAIL mem_retire: pc_write %0d retired %0d required 3 2", n_pcwrite, retired);
        end
        checks++;
        if (onehot_err !== 0) begin errors++; $display("FAIL mem_onehot: got %0d violations required 0", onehot_err); end
    endtask

    task automatic test_timeout();
        defaults();
        prog[0] = OP_R; prog_len = 1; imem_delay = 1000;
        run_prog(32'h80, 16'd0);
        checks++;
        if (n_fetch !== 15) begin errors++; $display("FAIL timeout_fetch_cycles: got %0d required 15", n_fetch); end
        checks++;
        if ({done, err_timeout, err_illegal} !== 3'b110) begin
            errors++; $display("FAIL timeout_flags: got %b required 110", {done, err_timeout, err_illegal});
        end
        checks++;
        if (retired !== 16'd0 || n_pcwrite !== 1) begin
            errors++; $display("FAIL timeout_retired: retired %0d pc_write %0d required 0 1", retired, n_pcwrite);
        end
    endtask

    task automatic test_illegal();
        defaults();
        prog[0] = OP_R; prog[1] = OP_BAD; prog_len = 2;
        run_prog(32'hC0, 16'd0);
        checks++;
        if ({done, err_illegal, err_timeout} !== 3'b110) begin
            errors++; $display("FAIL illegal_flags: got %b required 110", {done, err_illegal, err_timeout});
        end
        checks++;
        if (done_cyc - first_fetch !== 7) begin errors++; $display("FAIL illegal_latency: got %0d required 7", done_cyc - first_fetch); end
        checks++;
        if (n_pcwrite !== 2 || retired !== 16'd1) begin
            errors++; $display("FAIL illegal_pcwrite: pc_write %0d retired %0d required 2 1", n_pcwrite, retired);
        end
    endtask

    task automatic test_halt();
        defaults();
        prog[0] = OP_R; prog[1] = OP_LW; prog[2] = OP_R; prog[3] = OP_R; prog_len = 4;
        dmem_delay = 2; halt_at_instr = 2;
        run_prog(32'h100, 16'd0);
        checks++;
        if (retired !== 16'd2) begin errors++; $display("FAIL halt_retired: got %0d required 2", retired); end
        checks++;
        if ({done, err_illegal, err_timeout} !== 3'b100) begin
            errors++; $display("FAIL halt_status: got %b required 100", {done, err_illegal, err_timeout});
        end
        checks++;
        if (n_memread !== 3 || n_regwrite !== 2) begin
            errors++; $display("FAIL halt_complete: mem_read %0d reg_write %0d required 3 2", n_memread, n_regwrite);
        end
    endtask

    task automatic test_start_while_busy();
        defaults();
        for (int i = 0; i < 8; i++) prog[i] = OP_R;
        prog_len = 8; busy_start_at = 7;
        run_prog(32'h200, 16'd4);
        checks++;
        if (ep_out !== 32'h200) begin errors++; $display("FAIL busy_start_ep: got %h required 200", ep_out); end
        checks++;
        if (retired !== 16'd4 || n_pcint !== 1) begin
            errors++; $display("FAIL busy_start_retired: retired %0d pc_int %0d required 4 1", retired, n_pcint);
        end
    endtask

    task automatic test_reset_mid_run();
        bit found = 0;
        opcode = OP_R; imem_ready = 1'b1; dmem_ready = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        entry_point = 32'h44; run_len = 16'd0; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (reg_write) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midrst_reach_wb: reg_write never seen, required 1"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({pc_int, pc_write, fetch_en, reg_write, mem_read, mem_write, busy, done, err_illegal, err_timeout} !== 10'b0) begin
            errors++; $display("FAIL midrst_ctrl: got %b required 0", {pc_int, pc_write, fetch_en, reg_write, mem_read, mem_write, busy, done, err_illegal, err_timeout});
        end
        checks++;
        if (ep_out !== 32'h0 || retired !== 16'h0) begin
            errors++; $display("FAIL midrst_regs: ep_out %h retired %0d required 0 0", ep_out, retired);
        end
        rst = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mem_stall();
        test_timeout();
        test_illegal();
        test_halt();
        test_start_while_busy();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
